hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Central pipeline sequencer for the 5-stage MIPS core with external memories.
//  - Detects load-use hazards between the ID and EX stages. The EX forwarding unit cannot cover these.
//  - Freezes the pipeline while a data-memory access is outstanding.
//  - Bubbles IF/ID while an instruction fetch is not ready.
//  - Flushes the younger stages on a taken branch.
//  Drives all PC and pipeline-register write, bubble and flush controls.
// PARAMETERS
//  MEM_TIMEOUT  255  Max consecutive DMEM_WAIT cycles before the ERR state (1..65535).
//  CNT_W        16   Width of the saturating stall-cycle counter.
// PORTS
//  clk              in   1      Core clock; all state updates on rising edge.
//  rst              in   1      Synchronous, active-high reset.
//  opcode_ID        in   6      Opcode of the instruction in ID.
//  ID_RS, ID_RT     in   5      Source register fields of the instruction in ID.
//  opcode_EX        in   6      Opcode of the instruction in EX.
//  EX_RT            in   5      rt (load destination) of the instruction in EX.
//  branch_taken_EX  in   1      Branch in EX resolved taken this cycle.
//  dmem_req         in   1      lw/sw in MEM is requesting data memory.
//  dmem_ready       in   1      Data memory completes the request this cycle.
//  imem_ready       in   1      Instruction memory returns a valid word this cycle.
//  PC_write         out  1      Enable PC update.
//  IF_ID_write      out  1      Enable IF/ID register load.
//  IF_ID_flush      out  1      Load NOP into IF/ID (wins over IF_ID_write).
//  ID_EX_write      out  1      Enable ID/EX register load.
//  ID_EX_bubble     out  1      Load NOP (all controls 0) into ID/EX.
//  EX_MEM_write     out  1      Enable EX/MEM register load.
//  MEM_WB_bubble    out  1      Load NOP into MEM/WB.
//  mem_err          out  1      Sticky DMEM timeout flag.
//  stall_cnt        out  CNT_W  Saturating count of cycles with PC_write==0 (excluding reset).
// BEHAVIOUR
//  State: RUN, DMEM_WAIT, ERR (registered). wait_cnt is 16 bits.
//  Outputs are combinational from state and inputs. No added latency.
//  Reset (rst=1 at edge): state<=RUN, wait_cnt<=0, mem_err<=0, stall_cnt<=0.
//  While rst=1, outputs are:
//    PC_write=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_write=0
//    IF_ID_flush=1, ID_EX_bubble=1, MEM_WB_bubble=1
//  A reset mid-wait abandons the access.
//  Default (RUN, no event): all *_write=1; flush/bubble=0.
//  load_use definition:
//    opcode_EX==6'b100011 && EX_RT!=0
//    && (EX_RT==ID_RS || (EX_RT==ID_RT && opcode_ID in {000000,000100,101011}))
//  Cycle priority, highest first:
//  1 state ERR: freeze. All writes=0, MEM_WB_bubble=1, mem_err=1. Exit only via rst.
//  2 dmem_req && !dmem_ready (RUN or DMEM_WAIT): freeze.
//    - PC/IF_ID/ID_EX/EX_MEM write=0, MEM_WB_bubble=1.
//    - RUN->DMEM_WAIT with wait_cnt<=1; in DMEM_WAIT, wait_cnt++.
//    - If wait_cnt==MEM_TIMEOUT while still not ready: ->ERR, mem_err<=1.
//  3 dmem_ready (or !dmem_req) in DMEM_WAIT: ->RUN, wait_cnt<=0.
//    That cycle evaluates rules 4-6 normally, so the pipeline advances.
//  4 branch_taken_EX: PC_write=1, IF_ID_flush=1, ID_EX_bubble=1.
//    Overrides load_use and an imem stall, because the younger instructions are discarded.
//  5 load_use: PC_write=0, IF_ID_write=0, ID_EX_bubble=1; EX_MEM advances.
//    Exactly one bubble: next cycle the lw is in MEM and EX holds the NOP.
//  6 !imem_ready: PC_write=0, IF_ID_flush=1; ID and later advance.
//    If load_use coincides, rule 5 applies and IF/ID holds.
//  A branch held during a DMEM freeze takes effect on the release cycle.
//  stall_cnt increments when rst=0 and PC_write=0, and saturates at all-ones.
// TESTING
//  T1 load-use: lw $8 in EX, add $9,$8,$3 in ID, all ready
//     -> one cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1; then default; stall_cnt=1.
//  T2 lw $8 in EX, addi $9,$8,4 in ID (opcode 001000, rt=$8 is dest)
//     -> no stall. Same with EX_RT=0 -> no stall.
//  T3 dmem_req=1, dmem_ready low 3 cycles then high
//     -> 3 frozen cycles (MEM_WB_bubble=1), state DMEM_WAIT, then RUN.
//     -> release cycle all writes=1; stall_cnt=3.
//  T4 MEM_TIMEOUT=4, dmem_ready never asserted
//     -> ERR entered after 5 frozen cycles; mem_err=1 sticky until rst; rst returns to RUN.
//  T5 branch_taken_EX with load_use and imem_ready=0 in the same cycle
//     -> PC_write=1, IF_ID_flush=1, ID_EX_bubble=1.
//  T6 branch_taken_EX during a dmem freeze
//     -> no flush until the dmem_ready cycle, then flush outputs are asserted.
//     -> rst mid-DMEM_WAIT returns to RUN with wait_cnt=0.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Central pipeline sequencer for the 5-stage MIPS core with external memories.
// Detects load-use hazards, freezes the pipeline during outstanding data-memory
// accesses, bubbles IF/ID on instruction-fetch stalls and flushes the younger
// stages on a taken branch. All control outputs are combinational from the
// registered state and the current inputs.
module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode_ID,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic [5:0]       opcode_EX,
    input  logic [4:0]       EX_RT,
    input  logic             branch_taken_EX,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_write,
    output logic             MEM_WB_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] S_RUN       = 2'd0;
    localparam logic [1:0] S_DMEM_WAIT = 2'd1;
    localparam logic [1:0] S_ERR       = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;

    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    logic [1:0]       r_state;
    logic [15:0]      r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [1:0]       w_state_nxt;
    logic [15:0]      w_wait_nxt;
    logic             w_err_nxt;
    logic             w_dmem_stall;
    logic             w_rt_is_src;
    logic             w_load_use;

    // Hazard conditions: an lw in EX whose destination is read by the ID instruction.
    // rt is only a source for R-type, beq and sw; for I-type ALU ops and lw it is the
    // destination and cannot create a load-use dependency.
    assign w_dmem_stall = dmem_req && !dmem_ready;
    assign w_rt_is_src  = (opcode_ID == OP_RTYPE) || (opcode_ID == OP_BEQ) ||
                          (opcode_ID == OP_SW);
    assign w_load_use   = (opcode_EX == OP_LW) && (EX_RT != 5'd0) &&
                          ((EX_RT == ID_RS) || ((EX_RT == ID_RT) && w_rt_is_src));

    // Pipeline control outputs, resolved by cycle priority.
    always_comb begin
        // NOTE: every output gets a default before the priority chain so no path
        // leaves one unassigned, which would otherwise infer a latch.
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_write   = 1'b1;
        ID_EX_bubble  = 1'b0;
        EX_MEM_write  = 1'b1;
        MEM_WB_bubble = 1'b0;
        if (rst) begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            IF_ID_flush   = 1'b1;
            ID_EX_bubble  = 1'b1;
            MEM_WB_bubble = 1'b1;
        end else if ((r_state == S_ERR) || w_dmem_stall) begin
            // Full freeze: nothing advances, MEM/WB drains a NOP.
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (branch_taken_EX) begin
            // Younger instructions are discarded, so load-use and imem stalls are moot.
            IF_ID_flush   = 1'b1;
            ID_EX_bubble  = 1'b1;
        end else if (w_load_use) begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_bubble  = 1'b1;
        end else if (!imem_ready) begin
            PC_write      = 1'b0;
            IF_ID_flush   = 1'b1;
        end
    end

    // Next-state logic for the data-memory wait tracker.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_err_nxt   = r_mem_err;
        case (r_state)
            S_RUN: begin
                if (w_dmem_stall) begin
                    w_state_nxt = S_DMEM_WAIT;
                    w_wait_nxt  = 16'd1;
                end
            end
            S_DMEM_WAIT: begin
                if (w_dmem_stall) begin
                    if (r_wait_cnt == TIMEOUT) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_wait_nxt  = r_wait_cnt + 16'd1;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                    w_wait_nxt  = 16'd0;
                end
            end
            S_ERR: begin
                // Sticky until reset.
            end
            default: begin
                w_state_nxt = S_RUN;
                w_wait_nxt  = 16'd0;
            end
        endcase
    end

    // State registers with synchronous reset; stall counter saturates at all-ones.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= 16'd0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_mem_err  <= w_err_nxt;
            if (!PC_write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: a table of single-cycle
// control vectors, hand-written multi-cycle sequences and a randomized run
// compared against a cycle-count reference model.
module tb_hazard_stall_controller;

    localparam int TO    = 4;
    localparam int CW    = 5;
    localparam int SAT   = (1 << CW) - 1;

    // Control bundle order: PC_w, IF_ID_w, IF_ID_flush, ID_EX_w, ID_EX_bubble, EX_MEM_w, MEM_WB_bubble
    localparam logic [6:0] C_DEF = 7'b1101010;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_IM  = 7'b0111010;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_RST = 7'b0010101;

    typedef struct packed {
        logic       rst;
        logic [5:0] op_id;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [5:0] op_ex;
        logic [4:0] ex_rt;
        logic       br;
        logic       dreq;
        logic       drdy;
        logic       irdy;
    } in_t;

    typedef struct {
        in_t        i;
        logic [6:0] exp;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [5:0]    opcode_ID;
    logic [4:0]    ID_RS;
    logic [4:0]    ID_RT;
    logic [5:0]    opcode_EX;
    logic [4:0]    EX_RT;
    logic          branch_taken_EX;
    logic          dmem_req;
    logic          dmem_ready;
    logic          imem_ready;
    logic          PC_write;
    logic          IF_ID_write;
    logic          IF_ID_flush;
    logic          ID_EX_write;
    logic          ID_EX_bubble;
    logic          EX_MEM_write;
    logic          MEM_WB_bubble;
    logic          mem_err;
    logic [CW-1:0] stall_cnt;

    hazard_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .opcode_ID(opcode_ID), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .opcode_EX(opcode_EX), .EX_RT(EX_RT),
        .branch_taken_EX(branch_taken_EX),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_write(ID_EX_write), .ID_EX_bubble(ID_EX_bubble),
        .EX_MEM_write(EX_MEM_write), .MEM_WB_bubble(MEM_WB_bubble),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Sampled DUT values and model predictions for the current cycle.
    logic [6:0]    s_ctrl;
    logic          s_err;
    logic [CW-1:0] s_cnt;
    logic [6:0]    p_ctrl;
    logic          p_err;
    logic [CW-1:0] p_cnt;

    // Reference model: how many consecutive unfinished dmem cycles have been
    // seen, whether the timeout fired, and how many PC-held cycles occurred.
    bit m_err     = 1'b0;
    int m_waited  = 0;
    int m_stall   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic in_t nop();
        in_t v;
        v = '0;
        v.irdy = 1'b1;
        return v;
    endfunction

    function automatic in_t lu_base();
        in_t v;
        v = nop();
        v.op_ex = 6'b100011;
        v.ex_rt = 5'd8;
        v.op_id = 6'b000000;
        v.rs    = 5'd8;
        v.rt    = 5'd3;
        return v;
    endfunction

    function automatic logic [6:0] model_ctrl(input in_t v, input bit err);
        bit lw_in_ex;
        bit rt_is_src;
        bit hazard;
        lw_in_ex  = (v.op_ex == 6'b100011) && (v.ex_rt != 5'd0);
        rt_is_src = v.op_id inside {6'b000000, 6'b000100, 6'b101011};
        hazard    = lw_in_ex && ((v.ex_rt == v.rs) || (rt_is_src && v.ex_rt == v.rt));
        if (v.rst)                  return C_RST;
        if (err)                    return C_FRZ;
        if (v.dreq && !v.drdy)      return C_FRZ;
        if (v.br)                   return C_BR;
        if (hazard)                 return C_LU;
        if (!v.irdy)                return C_IM;
        return C_DEF;
    endfunction

    // One clock cycle: drive at the falling edge, sample mid low phase, advance model.
    task automatic step(input in_t v);
        @(negedge clk);
        rst             = v.rst;
        opcode_ID       = v.op_id;
        ID_RS           = v.rs;
        ID_RT           = v.rt;
        opcode_EX       = v.op_ex;
        EX_RT           = v.ex_rt;
        branch_taken_EX = v.br;
        dmem_req        = v.dreq;
        dmem_ready      = v.drdy;
        imem_ready      = v.irdy;
        #2;
        s_ctrl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
                  EX_MEM_write, MEM_WB_bubble};
        s_err  = mem_err;
        s_cnt  = stall_cnt;
        p_ctrl = model_ctrl(v, m_err);
        p_err  = m_err;
        p_cnt  = CW'(m_stall);
        if (v.rst) begin
            m_err    = 1'b0;
            m_waited = 0;
            m_stall  = 0;
        end else begin
            if (p_ctrl[6] == 1'b0) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            if (!m_err) begin
                if (v.dreq && !v.drdy) begin
                    // The access that has already waited TO extra cycles gives up.
                    if (m_waited == TO) m_err = 1'b1;
                    else                m_waited = m_waited + 1;
                end else begin
                    m_waited = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        in_t v;
        v = nop();
        v.rst = 1'b1;
        step(v);
    endtask

    vec_t tbl[14];

    initial begin
        in_t v;

        // Single-cycle vectors from RUN with no data-memory activity.
        tbl[0].i  = nop();                                                   tbl[0].exp  = C_DEF;
        tbl[1].i  = lu_base();                                               tbl[1].exp  = C_LU;
        tbl[2].i  = lu_base(); tbl[2].i.op_id = 6'b001000;
        tbl[2].i.rs = 5'd3; tbl[2].i.rt = 5'd8;                              tbl[2].exp  = C_DEF;
        tbl[3].i  = lu_base(); tbl[3].i.ex_rt = 5'd0;
        tbl[3].i.rs = 5'd0; tbl[3].i.rt = 5'd0;                              tbl[3].exp  = C_DEF;
        tbl[4].i  = lu_base(); tbl[4].i.op_id = 6'b000100;
        tbl[4].i.rs = 5'd1; tbl[4].i.rt = 5'd8;                              tbl[4].exp  = C_LU;
        tbl[5].i  = lu_base(); tbl[5].i.op_id = 6'b101011;
        tbl[5].i.rs = 5'd2; tbl[5].i.rt = 5'd8;                              tbl[5].exp  = C_LU;
        tbl[6].i  = lu_base(); tbl[6].i.op_id = 6'b100011;
        tbl[6].i.rs = 5'd2; tbl[6].i.rt = 5'd8;                              tbl[6].exp  = C_DEF;
        tbl[7].i  = lu_base(); tbl[7].i.op_ex = 6'b101011;                   tbl[7].exp  = C_DEF;
        tbl[8].i  = nop(); tbl[8].i.irdy = 1'b0;                             tbl[8].exp  = C_IM;
        tbl[9].i  = lu_base(); tbl[9].i.irdy = 1'b0;                         tbl[9].exp  = C_LU;
        tbl[10].i = nop(); tbl[10].i.br = 1'b1;                              tbl[10].exp = C_BR;
        tbl[11].i = lu_base(); tbl[11].i.br = 1'b1; tbl[11].i.irdy = 1'b0;   tbl[11].exp = C_BR;
        tbl[12].i = nop(); tbl[12].i.br = 1'b1; tbl[12].i.irdy = 1'b0;       tbl[12].exp = C_BR;
        tbl[13].i = nop(); tbl[13].i.dreq = 1'b1; tbl[13].i.drdy = 1'b1;     tbl[13].exp = C_DEF;

        rst = 1'b1; opcode_ID = '0; ID_RS = '0; ID_RT = '0; opcode_EX = '0; EX_RT = '0;
        branch_taken_EX = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b1;

        // Reset: outputs forced, counters cleared after the first edge.
        do_reset();
        do_reset();
        check("reset_ctrl", 32'(s_ctrl), 32'(C_RST));
        check("reset_err", 32'(s_err), 32'd0);
        check("reset_cnt", 32'(s_cnt), 32'd0);

        // T1: single load-use bubble, then default with one stall counted.
        step(lu_base());
        check("t1_lu", 32'(s_ctrl), 32'(C_LU));
        step(nop());
        check("t1_after", 32'(s_ctrl), 32'(C_DEF));
        check("t1_cnt", 32'(s_cnt), 32'd1);

        for (int k = 0; k < 14; k++) begin
            step(tbl[k].i);
            check($sformatf("tbl%0d", k), 32'(s_ctrl), 32'(tbl[k].exp));
        end

        // T3: three frozen cycles then release with everything advancing.
        do_reset();
        v = nop(); v.dreq = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(v);
            check($sformatf("t3_frz%0d", k), 32'(s_ctrl), 32'(C_FRZ));
        end
        v.drdy = 1'b1;
        step(v);
        check("t3_release", 32'(s_ctrl), 32'(C_DEF));
        check("t3_cnt", 32'(s_cnt), 32'd3);

        // T4: timeout after five frozen cycles, sticky until reset.
        do_reset();
        v = nop(); v.dreq = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(v);
            check($sformatf("t4_frz%0d", k), 32'({s_ctrl, s_err}), 32'({C_FRZ, 1'b0}));
        end
        step(v);
        check("t4_err", 32'({s_ctrl, s_err}), 32'({C_FRZ, 1'b1}));
        v = nop(); v.br = 1'b1;
        step(v);
        check("t4_sticky", 32'({s_ctrl, s_err}), 32'({C_FRZ, 1'b1}));
        step(nop());
        check("t4_sticky2", 32'({s_ctrl, s_err}), 32'({C_FRZ, 1'b1}));
        check("t4_cnt", 32'(s_cnt), 32'd7);
        do_reset();
        check("t4_rst", 32'(s_ctrl), 32'(C_RST));
        step(nop());
        check("t4_run", 32'({s_ctrl, s_err}), 32'({C_DEF, 1'b0}));
        check("t4_cnt0", 32'(s_cnt), 32'd0);

        // T6: branch held through a freeze takes effect on the release cycle.
        do_reset();
        v = nop(); v.dreq = 1'b1; v.br = 1'b1;
        step(v);
        check("t6_frz0", 32'(s_ctrl), 32'(C_FRZ));
        step(v);
        check("t6_frz1", 32'(s_ctrl), 32'(C_FRZ));
        v.drdy = 1'b1;
        step(v);
        check("t6_release", 32'(s_ctrl), 32'(C_BR));

        // Reset mid-wait abandons the access: a new one gets the full timeout.
        v = nop(); v.dreq = 1'b1;
        step(v);
        step(v);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(v);
            check($sformatf("t6_rewait%0d", k), 32'({s_ctrl, s_err}), 32'({C_FRZ, 1'b0}));
        end
        step(v);
        check("t6_reerr", 32'(s_err), 32'd1);

        // Stall counter saturation.
        do_reset();
        v = nop(); v.irdy = 1'b0;
        for (int k = 0; k < 33; k++) begin
            step(v);
            if (k == 30) check("sat_below", 32'(s_cnt), 32'd30);
        end
        check("sat_top", 32'(s_cnt), 32'(SAT));

        // Randomized run against the reference model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            v       = '0;
            v.rst   = ($urandom_range(0, 63) == 0);
            case ($urandom_range(0, 4))
                0: v.op_id = 6'b000000;
                1: v.op_id = 6'b000100;
                2: v.op_id = 6'b101011;
                3: v.op_id = 6'b001000;
                default: v.op_id = 6'b100011;
            endcase
            v.rs    = 5'($urandom_range(0, 3));
            v.rt    = 5'($urandom_range(0, 3));
            v.op_ex = ($urandom_range(0, 1) == 1) ? 6'b100011 : 6'b000000;
            v.ex_rt = 5'($urandom_range(0, 3));
            v.br    = ($urandom_range(0, 7) == 0);
            v.dreq  = ($urandom_range(0, 2) == 0);
            v.drdy  = ($urandom_range(0, 2) == 0);
            v.irdy  = ($urandom_range(0, 3) != 0);
            step(v);
            check($sformatf("rand%0d", k), 32'({s_ctrl, s_err, s_cnt}),
                  32'({p_ctrl, p_err, p_cnt}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
